branch_predictor: RTL and testbench



---
 rtl/branch_predictor_pkg.sv | 25 ++
 rtl/branch_predictor_if.sv | 23 ++
 rtl/branch_predictor_sat_counter2.sv | 32 +++
 rtl/branch_predictor.sv | 81 ++++++++
 tb/tb_branch_predictor.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared types for the branch target buffer: word type, 2-bit direction
// counter states and the BTB entry layout.
package branch_predictor_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } pred_cnt_t;

  localparam int BTB_DEF_ENTRIES = 8;
  // Tag is pc[31:IDX_W+2] for the default table depth.
  localparam int BTB_TAG_W = 30 - $clog2(BTB_DEF_ENTRIES);

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    word_t                target;
    pred_cnt_t            cnt;
  } btb_entry_t;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side prediction and execute-side training bundle for the BTB.
interface bp_if;
  import branch_predictor_pkg::*;

  word_t pc;
  logic  pred_control;
  word_t pred_branch;
  logic  upd_en;
  word_t upd_pc;
  logic  upd_taken;
  word_t upd_target;

  modport bp (
    input  pc, upd_en, upd_pc, upd_taken, upd_target,
    output pred_control, pred_branch
  );

  modport tb (
    output pc, upd_en, upd_pc, upd_taken, upd_target,
    input  pred_control, pred_branch
  );

endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// Combinational 2-bit saturating counter step; inc wins if both are set.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  pred_cnt_t cnt,
  input  logic      inc,
  input  logic      dec,
  output pred_cnt_t cnt_next
);

  always_comb begin
    cnt_next = cnt;
    if (inc) begin
      unique case (cnt)
        STRONG_NT: cnt_next = WEAK_NT;
        WEAK_NT:   cnt_next = WEAK_T;
        WEAK_T:    cnt_next = STRONG_T;
        STRONG_T:  cnt_next = STRONG_T;
        default:   cnt_next = cnt;
      endcase
    end else if (dec) begin
      unique case (cnt)
        STRONG_NT: cnt_next = STRONG_NT;
        WEAK_NT:   cnt_next = STRONG_NT;
        WEAK_T:    cnt_next = WEAK_NT;
        STRONG_T:  cnt_next = WEAK_T;
        default:   cnt_next = cnt;
      endcase
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters: combinational lookup on
// the fetch PC, single-entry training per cycle from resolved branches.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input logic CLK,
  input logic nRST,
  bp_if.bp    bpif
);

  function automatic logic [BTB_TAG_W-1:0] tag_of(input word_t a);
    word_t s;
    s = a >> (IDX_W + 2);
    return s[BTB_TAG_W-1:0];
  endfunction

  btb_entry_t tbl_q [ENTRIES];

  // Lookup path: reads only pc and the table, never the update inputs.
  logic [IDX_W-1:0] lk_idx;
  btb_entry_t       lk_entry;
  logic             lk_hit;

  assign lk_idx   = bpif.pc[IDX_W+1:2];
  assign lk_entry = tbl_q[lk_idx];
  assign lk_hit   = lk_entry.valid && (lk_entry.tag == tag_of(bpif.pc));

  assign bpif.pred_control = lk_hit && lk_entry.cnt[1];
  assign bpif.pred_branch  = (lk_hit && lk_entry.cnt[1]) ? lk_entry.target : '0;

  logic [IDX_W-1:0] up_idx;
  btb_entry_t       up_entry;
  logic             up_hit;
  pred_cnt_t        up_cnt_next;
  btb_entry_t       up_entry_d;
  logic             up_we;

  assign up_idx   = bpif.upd_pc[IDX_W+1:2];
  assign up_entry = tbl_q[up_idx];
  assign up_hit   = up_entry.valid && (up_entry.tag == tag_of(bpif.upd_pc));

  sat_counter2 u_cnt (
    .cnt      (up_entry.cnt),
    .inc      (bpif.upd_en && up_hit && bpif.upd_taken),
    .dec      (bpif.upd_en && up_hit && !bpif.upd_taken),
    .cnt_next (up_cnt_next)
  );

  always_comb begin
    up_we      = 1'b0;
    up_entry_d = up_entry;
    if (bpif.upd_en) begin
      if (up_hit) begin
        up_we          = 1'b1;
        up_entry_d.cnt = up_cnt_next;
        if (bpif.upd_taken) up_entry_d.target = bpif.upd_target;
      end else if (bpif.upd_taken) begin
        // Taken miss replaces whatever occupies the slot.
        up_we             = 1'b1;
        up_entry_d.valid  = 1'b1;
        up_entry_d.tag    = tag_of(bpif.upd_pc);
        up_entry_d.target = bpif.upd_target;
        up_entry_d.cnt    = WEAK_T;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_q[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: WEAK_NT};
      end
    end else if (up_we) begin
      tbl_q[up_idx] <= up_entry_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default 8 entries).
module tb_branch_predictor;
  import branch_predictor_pkg::*;

  logic clk;
  logic nrst;
  int   errors;
  int   checks;

  bp_if bus ();

  branch_predictor dut (
    .CLK  (clk),
    .nRST (nrst),
    .bpif (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic exp_ctl, input word_t exp_tgt);
    logic [32:0] obs;
    logic [32:0] exp;
    obs = {bus.pred_control, bus.pred_branch};
    exp = {exp_ctl, exp_tgt};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed ctl=%0b tgt=%h expected ctl=%0b tgt=%h",
             tag, obs[32], obs[31:0], exp[32], exp[31:0]);
    end
  endtask

  task automatic look(input word_t a);
    bus.pc = a;
    #1;
  endtask

  task automatic upd(input word_t a, input logic taken, input word_t tgt);
    bus.upd_en     = 1'b1;
    bus.upd_pc     = a;
    bus.upd_taken  = taken;
    bus.upd_target = tgt;
    @(posedge clk);
    #1;
    bus.upd_en = 1'b0;
  endtask

  initial begin
    errors         = 0;
    checks         = 0;
    nrst           = 1'b0;
    bus.pc         = 32'h40;
    bus.upd_en     = 1'b0;
    bus.upd_pc     = '0;
    bus.upd_taken  = 1'b0;
    bus.upd_target = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_held", 1'b0, 32'h0);
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_released", 1'b0, 32'h0);

    upd(32'h100, 1'b1, 32'h200);
    look(32'h100);
    chk("alloc_weak_t", 1'b1, 32'h200);

    upd(32'h100, 1'b0, 32'h0);
    look(32'h100);
    chk("nt_to_weak_nt", 1'b0, 32'h0);
    upd(32'h100, 1'b1, 32'h200);
    look(32'h100);
    chk("t_to_weak_t", 1'b1, 32'h200);
    upd(32'h100, 1'b1, 32'h200);
    look(32'h100);
    chk("t_to_strong_t", 1'b1, 32'h200);
    upd(32'h100, 1'b1, 32'h200);
    upd(32'h100, 1'b0, 32'h0);
    look(32'h100);
    chk("strong_sat_then_nt", 1'b1, 32'h200);
    upd(32'h100, 1'b0, 32'h0);
    look(32'h100);
    chk("nt_to_weak_nt_2", 1'b0, 32'h0);
    upd(32'h100, 1'b0, 32'h0);
    upd(32'h100, 1'b0, 32'h0);
    look(32'h100);
    chk("sat_strong_nt", 1'b0, 32'h0);
    upd(32'h100, 1'b1, 32'h200);
    look(32'h100);
    chk("from_strong_nt_one_t", 1'b0, 32'h0);
    upd(32'h100, 1'b1, 32'h220);
    look(32'h100);
    chk("from_strong_nt_two_t", 1'b1, 32'h220);

    look(32'h120);
    chk("alias_miss", 1'b0, 32'h0);
    upd(32'h120, 1'b1, 32'h300);
    look(32'h120);
    chk("alias_alloc", 1'b1, 32'h300);
    look(32'h100);
    chk("alias_evicted", 1'b0, 32'h0);

    upd(32'h100, 1'b1, 32'h200);
    look(32'h100);
    chk("realloc", 1'b1, 32'h200);
    upd(32'h140, 1'b0, 32'h999);
    look(32'h140);
    chk("nt_no_alloc", 1'b0, 32'h0);
    look(32'h100);
    chk("nt_miss_keeps_occupant", 1'b1, 32'h200);

    @(negedge clk);
    bus.pc         = 32'h100;
    bus.upd_en     = 1'b1;
    bus.upd_pc     = 32'h100;
    bus.upd_taken  = 1'b1;
    bus.upd_target = 32'h280;
    #1;
    chk("no_bypass_old", 1'b1, 32'h200);
    @(posedge clk);
    #1;
    bus.upd_en = 1'b0;
    chk("no_bypass_new", 1'b1, 32'h280);

    upd(32'h104, 1'b1, 32'h500);
    look(32'h104);
    chk("second_index", 1'b1, 32'h500);
    look(32'h100);
    chk("first_index_kept", 1'b1, 32'h280);

    @(negedge clk);
    bus.pc         = 32'h100;
    bus.upd_en     = 1'b1;
    bus.upd_pc     = 32'h108;
    bus.upd_taken  = 1'b1;
    bus.upd_target = 32'h600;
    #2;
    nrst = 1'b0;
    #1;
    chk("midreset_immediate", 1'b0, 32'h0);
    @(posedge clk);
    #1;
    bus.upd_en = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    #1;
    look(32'h100);
    chk("midreset_cleared", 1'b0, 32'h0);
    look(32'h104);
    chk("midreset_cleared_104", 1'b0, 32'h0);
    look(32'h108);
    chk("midreset_upd_dropped", 1'b0, 32'h0);

    upd(32'h108, 1'b1, 32'h600);
    look(32'h108);
    chk("post_reset_alloc", 1'b1, 32'h600);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
